mem_arbiter: RTL and testbench

Responder side of the datapath memory handshake. It accepts instruction-fetch requests from the fetch stage and data load/store requests from the memory stage. It arbitrates them onto the single-port RAM and returns the per-port wait (hit) signals that the pipeline registers use to stall or advance. Data requests have priority over instruction requests. Accesses that never complete are flagged through a sticky error.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/mem_arbiter_access_timer.sv | 22 ++
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the memory handshake and its arbiter
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, ERR} arb_state_t;
endpackage

// File: rtl/mem_arbiter_access_timer.sv
// access_timer: saturating per-access cycle counter that flags the final allowed cycle
module access_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX = W'(TIMEOUT);
  logic [W-1:0] count;
  // count stalled access cycles, restart whenever the arbiter is idle
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != MAX) count <= count + 1'b1;
  // this cycle is the TIMEOUT-th stalled one, so the access gives up at this edge
  assign timeout = en && count >= LAST;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto the single-port RAM, data first
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);
  arb_state_t state, next_state;
  logic d_req, d_run, i_run, d_done, i_done, timeout;
  assign d_req = dREN | dWEN;
  assign d_run = state == D_ACC && d_req;
  assign i_run = state == I_ACC && iREN;
  assign d_done = d_run && ramstate == ACCESS;
  assign i_done = i_run && ramstate == ACCESS;
  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK(CLK),
    .nRST(nRST),
    .clr(state == IDLE),
    .en((d_run | i_run) && ramstate != ACCESS),
    .timeout(timeout)
  );
  // state register and sticky error flag
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      err <= 1'b0;
    end else begin
      state <= next_state;
      err <= err | (next_state == ERR);
    end
  // next state plus RAM and pipeline handshake outputs; a dropped request aborts the access
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = d_req ? D_ACC : iREN ? I_ACC : IDLE;
      D_ACC, I_ACC: next_state = !(d_run | i_run) ? IDLE :
                                 (ramstate == ERROR || timeout) ? ERR :
                                 ramstate == ACCESS ? IDLE : state;
      default: next_state = state;
    endcase
    ramWEN = d_run & dWEN;
    ramREN = i_run | (d_run & dREN & ~dWEN);
    ramaddr = state == D_ACC ? daddr : state == I_ACC ? iaddr : '0;
    ramstore = state == D_ACC ? dstore : '0;
    iwait = ~i_done;
    dwait = ~d_done;
    iload = i_done ? ramload : '0;
    dload = (d_done && !dWEN) ? ramload : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for the memory arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  word_t iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic iwait, dwait, ramREN, ramWEN, err;
  word_t iload, dload, ramaddr, ramstore;
  int checks = 0, errors = 0, ipulses = 0, dpulses = 0;
  word_t iq[$], dq[$];

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (!iwait) begin
      ipulses++;
      if (iq.size() == 0) chk("iwait_unexpected", 32'(iwait), 32'd1);
      else chk("iload", iload, iq.pop_front());
    end
    if (!dwait) begin
      dpulses++;
      if (dq.size() == 0) chk("dwait_unexpected", 32'(dwait), 32'd1);
      else chk("dload", dload, dq.pop_front());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iwait"}, 32'(iwait), 32'd1);
    chk({tag, "_dwait"}, 32'(dwait), 32'd1);
    chk({tag, "_ren"}, 32'(ramREN), 32'd0);
    chk({tag, "_wen"}, 32'(ramWEN), 32'd0);
    chk({tag, "_addr"}, ramaddr, 32'd0);
    chk({tag, "_store"}, ramstore, 32'd0);
    chk({tag, "_iload"}, iload, 32'd0);
    chk({tag, "_dload"}, dload, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    #1;
    step();
    nRST = 1'b1;
  endtask

  initial begin
    #1 chk_reset_outputs("reset");
    step(); step();
    nRST = 1'b1;

    step();
    iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    #1 chk("fetch_idle_ren", 32'(ramREN), 32'd0);
    observe();
    step();
    #1 chk("fetch_c1_ren", 32'(ramREN), 32'd1);
    chk("fetch_c1_addr", ramaddr, 32'h40);
    chk("fetch_c1_iwait", 32'(iwait), 32'd1);
    observe();
    step();
    #1 chk("fetch_c2_ren", 32'(ramREN), 32'd1);
    observe();
    step();
    ramstate = ACCESS; ramload = 32'h2408_0001; iq.push_back(32'h2408_0001);
    #1 chk("fetch_c3_ren", 32'(ramREN), 32'd1);
    chk("fetch_c3_iwait", 32'(iwait), 32'd0);
    observe();
    step();
    iREN = 0; ramstate = FREE;
    #1 chk("fetch_after_state", 32'(dut.state), 32'(IDLE));
    chk("fetch_after_iload", iload, 32'd0);
    observe();

    step();
    dREN = 1; daddr = 32'h80; iREN = 1; iaddr = 32'h44; ramstate = ACCESS; ramload = 32'h1111_2222;
    #1 chk("coll_idle_dwait", 32'(dwait), 32'd1);
    observe();
    step();
    ramload = 32'h3333_4444; dq.push_back(32'h3333_4444);
    #1 chk("coll_d_addr", ramaddr, 32'h80);
    chk("coll_d_ren", 32'(ramREN), 32'd1);
    chk("coll_d_iwait", 32'(iwait), 32'd1);
    chk("coll_d_dwait", 32'(dwait), 32'd0);
    observe();
    step();
    dREN = 0;
    #1 chk("coll_bubble_state", 32'(dut.state), 32'(IDLE));
    chk("coll_bubble_ren", 32'(ramREN), 32'd0);
    chk("coll_bubble_iwait", 32'(iwait), 32'd1);
    observe();
    step();
    ramload = 32'h5555_6666; iq.push_back(32'h5555_6666);
    #1 chk("coll_i_addr", ramaddr, 32'h44);
    chk("coll_i_iwait", 32'(iwait), 32'd0);
    observe();
    step();
    iREN = 0; ramstate = FREE;

    step();
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    #1 observe();
    step();
    #1 chk("store_wen", 32'(ramWEN), 32'd1);
    chk("store_ren", 32'(ramREN), 32'd0);
    chk("store_data", ramstore, 32'hDEAD_BEEF);
    chk("store_addr", ramaddr, 32'h100);
    chk("store_busy_dwait", 32'(dwait), 32'd1);
    observe();
    step();
    ramstate = ACCESS; ramload = 32'h77; dq.push_back(32'd0);
    #1 chk("store_done_dwait", 32'(dwait), 32'd0);
    observe();
    step();
    dREN = 0; dWEN = 0; ramstate = FREE;
    #1 chk("store_after_dwait", 32'(dwait), 32'd1);
    observe();

    step();
    iREN = 1; iaddr = 32'h200; ramstate = BUSY;
    #1 observe();
    step();
    #1 chk("flush_ren_on", 32'(ramREN), 32'd1);
    observe();
    step();
    iREN = 0;
    #1 chk("flush_ren_off", 32'(ramREN), 32'd0);
    chk("flush_iwait", 32'(iwait), 32'd1);
    observe();
    step();
    #1 chk("flush_state", 32'(dut.state), 32'(IDLE));

    step();
    iREN = 1; iaddr = 32'h300; ramstate = BUSY;
    for (int k = 1; k <= 4; k++) begin
      step();
      #1 chk($sformatf("to_c%0d_state", k), 32'(dut.state), 32'(I_ACC));
      chk($sformatf("to_c%0d_err", k), 32'(err), 32'd0);
      observe();
    end
    step();
    dREN = 1; ramstate = ACCESS;
    #1 chk("to_err", 32'(err), 32'd1);
    chk("to_state", 32'(dut.state), 32'(ERR));
    chk("to_iwait", 32'(iwait), 32'd1);
    chk("to_dwait", 32'(dwait), 32'd1);
    chk("to_ren", 32'(ramREN), 32'd0);
    observe();
    step();
    #1 chk("to_hold_err", 32'(err), 32'd1);
    chk("to_hold_wen", 32'(ramWEN), 32'd0);
    observe();
    apply_reset();
    #1 chk_reset_outputs("to_reset");

    step();
    dREN = 1; daddr = 32'h10; ramstate = ERROR;
    step();
    step();
    dREN = 0; ramstate = FREE;
    #1 chk("rerr_err", 32'(err), 32'd1);
    chk("rerr_state", 32'(dut.state), 32'(ERR));
    apply_reset();

    step();
    dWEN = 1; daddr = 32'h300; dstore = 32'h1234; ramstate = BUSY;
    step();
    #1 chk("ar_wen_on", 32'(ramWEN), 32'd1);
    #1 nRST = 0;
    #1 chk("ar_wen_off", 32'(ramWEN), 32'd0);
    chk("ar_dwait", 32'(dwait), 32'd1);
    dWEN = 0; ramstate = FREE; nRST = 1;
    #1 chk_reset_outputs("ar_release");
    step();
    #1 chk_reset_outputs("ar_idle");

    chk("ipulses", 32'(ipulses), 32'd2);
    chk("dpulses", 32'(dpulses), 32'd2);
    chk("queues_empty", 32'(iq.size() + dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
